// File: rtl/riscvboy_pkg.sv
// Shared definitions for the riscvboy instruction fetch path: default widths,
// reset fetch address and the {pc, instr} fetch-entry record.
package riscvboy_pkg;

  localparam int          RISCVBOY_PC_W     = 32;
  localparam int          RISCVBOY_INS_W    = 32;
  localparam int          RISCVBOY_DEPTH    = 4;
  localparam logic [31:0] RISCVBOY_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [RISCVBOY_PC_W-1:0]  pc;
    logic [RISCVBOY_INS_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/riscvboy_sync_fifo.sv
// Small synchronous FIFO with push, pop and a synchronous flush.
// Exposes occupancy, the head word and an empty flag. The asynchronous
// active-low reset clears pointers and storage so the head reads as zero.
module riscvboy_sync_fifo #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      din,
  output logic [DATA_W-1:0]      head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Pointer and occupancy bookkeeping; flush discards everything stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage, written at the tail on push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= din;
    end
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == '0);

endmodule

// File: rtl/riscvboy_ifetch_buf.sv
// Instruction prefetch buffer between the core fetch port and a
// registered-read imem (one cycle read latency). Issues sequential word reads
// under a credit rule that never overflows the FIFO, queues {pc, instr}
// entries, and presents the head to decode over valid/ready. A redirect
// flushes queued and in-flight fetches and restarts at the target.
//
// Optional feature macro: RISCVBOY_IFETCH_BYPASS_EN
//   When defined, a live response arriving while the FIFO is empty is
//   presented combinationally in the same cycle (and not stored if popped).
module riscvboy_ifetch_buf
  import riscvboy_pkg::*;
#(
  parameter int              PC_W     = RISCVBOY_PC_W,
  parameter int              INS_W    = RISCVBOY_INS_W,
  parameter int              DEPTH    = RISCVBOY_DEPTH,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RISCVBOY_RESET_PC)
) (
  input  logic             clk_sys,
  input  logic             rst,
  input  logic             i_redirect,
  input  logic [PC_W-1:0]  i_redirect_pc,
  output logic             o_instr_ren,
  output logic [PC_W-1:0]  o_instr_raddr,
  input  logic [INS_W-1:0] i_instr_dina,
  output logic             o_valid,
  output logic [INS_W-1:0] o_instr,
  output logic [PC_W-1:0]  o_pc,
  input  logic             i_ready
);

  localparam int CW  = $clog2(DEPTH) + 1;
  localparam int CRW = CW + 1;
  localparam int FW  = PC_W + INS_W;

  logic [PC_W-1:0] fpc;
  logic [PC_W-1:0] ipc;
  logic            inflt;
  logic            kill;

  logic [FW-1:0]   fifo_head;
  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            fifo_pop;
  logic            push;
  logic            pop;
  logic            live;
  logic            issue;
  logic [CRW-1:0]  credit;
  logic            unused_redirect_lsbs;

  // Redirect targets are word aligned; the byte offset is dropped.
  assign unused_redirect_lsbs = ^i_redirect_pc[1:0];

  // A returning response is live unless a redirect has marked it killed.
  assign live = inflt & ~kill;

`ifdef RISCVBOY_IFETCH_BYPASS_EN
  logic bypass;

  assign bypass   = fifo_empty & live;
  assign o_valid  = ~fifo_empty | bypass;
  assign o_pc     = bypass ? ipc          : fifo_head[FW-1:INS_W];
  assign o_instr  = bypass ? i_instr_dina : fifo_head[INS_W-1:0];
  assign pop      = o_valid & i_ready;
  assign fifo_pop = pop & ~fifo_empty;
  // A bypassed response that decode takes this cycle never enters storage.
  assign push     = live & ~i_redirect & ~(bypass & i_ready);
`else
  assign o_valid  = ~fifo_empty;
  assign o_pc     = fifo_head[FW-1:INS_W];
  assign o_instr  = fifo_head[INS_W-1:0];
  assign pop      = o_valid & i_ready;
  assign fifo_pop = pop;
  assign push     = live & ~i_redirect;
`endif

  // Credit: stored entries plus the outstanding read, less what leaves now.
  // Keeping this below DEPTH guarantees every response has a free slot.
  assign credit        = CRW'(fifo_count) + CRW'(inflt) - CRW'(pop);
  assign issue         = rst & ~i_redirect & (credit < CRW'(DEPTH));
  assign o_instr_ren   = issue;
  assign o_instr_raddr = fpc;

  // ---- issue stage -> response stage (imem registered read) ----
  // Fetch PC, in-flight tracking and kill flag for flushed responses.
  always_ff @(posedge clk_sys or negedge rst) begin
    if (!rst) begin
      fpc   <= RESET_PC;
      ipc   <= '0;
      inflt <= 1'b0;
      kill  <= 1'b0;
    end else begin
      inflt <= issue;
      // The response outstanding at a redirect is discarded; no read is
      // issued in the redirect cycle, so the flag clears one cycle later.
      kill  <= i_redirect & inflt;
      if (issue) ipc <= fpc;
      if (i_redirect)
        fpc <= {i_redirect_pc[PC_W-1:2], 2'b00};
      else if (issue)
        fpc <= fpc + PC_W'(4);
    end
  end

  // ---- response stage -> decode (FIFO storage) ----
  riscvboy_sync_fifo #(
    .DATA_W (FW),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk_sys),
    .rst_n (rst),
    .flush (i_redirect),
    .push  (push),
    .pop   (fifo_pop),
    .din   ({ipc, i_instr_dina}),
    .head  (fifo_head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_riscvboy_ifetch_buf.sv
// Bench for riscvboy_ifetch_buf: registered-read imem model, expected-stream
// scoreboard (sequential PCs from each restart point) and a negedge monitor.
module tb_riscvboy_ifetch_buf;
  import riscvboy_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef RISCVBOY_IFETCH_BYPASS_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 3;
`endif
  localparam int WIN = 1024;

  logic        clk_sys       = 1'b0;
  logic        rst           = 1'b1;
  logic        i_redirect    = 1'b0;
  logic [31:0] i_redirect_pc = 32'h0;
  logic        o_instr_ren;
  logic [31:0] o_instr_raddr;
  logic [31:0] i_instr_dina  = 32'h0;
  logic        o_valid;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_ready       = 1'b0;

  int checks = 0;
  int errors = 0;

  fetch_entry_t exp_q[$];
  logic [31:0]  exp_faddr  = RESET_PC;
  logic         hold_prev  = 1'b0;
  logic [31:0]  hold_pc    = 32'h0;
  logic [31:0]  hold_instr = 32'h0;

  always #5 clk_sys = ~clk_sys;

  riscvboy_ifetch_buf dut (
    .clk_sys       (clk_sys),
    .rst           (rst),
    .i_redirect    (i_redirect),
    .i_redirect_pc (i_redirect_pc),
    .o_instr_ren   (o_instr_ren),
    .o_instr_raddr (o_instr_raddr),
    .i_instr_dina  (i_instr_dina),
    .o_valid       (o_valid),
    .o_instr       (o_instr),
    .o_pc          (o_pc),
    .i_ready       (i_ready)
  );

  // imem contents: word k holds 0x1000_0000 + k, indexed by addr[13:2].
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return 32'h1000_0000 + {20'h0, a[13:2]};
  endfunction

  always @(posedge clk_sys) begin
    if (o_instr_ren) i_instr_dina <= word_at(o_instr_raddr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: after a restart at T, decode sees T, T+4, ... and the
  // imem sees reads at the same sequence of addresses.
  task automatic restart_model(input logic [31:0] t);
    logic [31:0] a;
    fetch_entry_t e;
    a = {t[31:2], 2'b00};
    exp_q.delete();
    exp_faddr = a;
    for (int i = 0; i < WIN; i++) begin
      e.pc    = a + 32'(4 * i);
      e.instr = word_at(e.pc);
      exp_q.push_back(e);
    end
  endtask

  // Monitor: compares every handshake and every imem read against the model.
  always @(negedge clk_sys) begin
    fetch_entry_t e;
    if (!rst) begin
      chk("reset_valid", {31'h0, o_valid}, 32'h0);
      chk("reset_ren", {31'h0, o_instr_ren}, 32'h0);
      chk("reset_pc", o_pc, 32'h0);
      chk("reset_instr", o_instr, 32'h0);
      chk("reset_raddr", o_instr_raddr, RESET_PC);
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        chk("hold_valid", {31'h0, o_valid}, 32'h1);
        chk("hold_pc", o_pc, hold_pc);
        chk("hold_instr", o_instr, hold_instr);
      end
      if (i_redirect) begin
        chk("ren_in_redirect", {31'h0, o_instr_ren}, 32'h0);
      end else if (o_instr_ren) begin
        chk("fetch_addr", o_instr_raddr, exp_faddr);
        exp_faddr = exp_faddr + 32'h4;
      end
      if (o_valid && i_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got pc %h with no entry expected at %0t", o_pc, $time);
        end else begin
          e = exp_q.pop_front();
          chk("out_pc", o_pc, e.pc);
          chk("out_instr", o_instr, e.instr);
        end
      end
      hold_prev  = o_valid && !i_ready && !i_redirect;
      hold_pc    = o_pc;
      hold_instr = o_instr;
    end
  end

  task automatic cyc();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic assert_reset();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic release_reset();
    rst = 1'b1;
    restart_model(RESET_PC);
  endtask

  task automatic start_redirect(input logic [31:0] t);
    i_redirect    = 1'b1;
    i_redirect_pc = t;
  endtask

  task automatic finish_redirect();
    cyc();
    restart_model(i_redirect_pc);
    i_redirect = 1'b0;
  endtask

  task automatic redirect_to(input logic [31:0] t);
    start_redirect(t);
    finish_redirect();
  endtask

  // Called right after a restart: first read address, then restart-to-valid
  // latency and the PC of the first valid entry.
  task automatic measure(input string name, input logic [31:0] want_pc);
    int lat;
    int k;
    lat = 0;
    k   = 0;
    while (lat == 0 && k < 12) begin
      @(negedge clk_sys);
      k++;
      if (k == 1) begin
        chk({name, "_first_ren"}, {31'h0, o_instr_ren}, 32'h1);
        chk({name, "_first_raddr"}, o_instr_raddr, want_pc);
      end
      if (o_valid) lat = k;
    end
    chk({name, "_latency"}, 32'(lat), 32'(LAT));
    if (lat != 0) chk({name, "_first_pc"}, o_pc, want_pc);
  endtask

  initial begin
    int n;
    int k;
    int found;
    int r;
    int seg;
    logic [31:0] t;

    #1 rst = 1'b0;
    repeat (3) cyc();

    // Reset release with decode always ready.
    i_ready = 1'b1;
    release_reset();
    measure("rst_release", RESET_PC);

    // Redirect in the same cycle as the pop of pc 0x40.
    found = 0;
    k = 0;
    while (found == 0 && k < 40) begin
      @(negedge clk_sys);
      k++;
      if (o_valid && o_pc == 32'h3C) found = 1;
    end
    chk("reach_pc_3c", 32'(found), 32'h1);
    cyc();
    start_redirect(32'h300);
    @(negedge clk_sys);
    chk("pop40_valid", {31'h0, o_valid}, 32'h1);
    chk("pop40_pc", o_pc, 32'h40);
    finish_redirect();
    measure("redir_pop", 32'h300);

    // Steady-state throughput.
    n = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (o_valid && i_ready) n++;
    end
    chk("throughput", 32'(n), 32'd20);

    // Backpressure from reset: exactly DEPTH reads, then issue stops.
    cyc();
    assert_reset();
    cyc();
    cyc();
    i_ready = 1'b0;
    release_reset();
    n = 0;
    repeat (10) begin
      @(negedge clk_sys);
      if (o_instr_ren) n++;
    end
    chk("hold_issue_count", 32'(n), 32'd4);
    chk("hold_ren_low", {31'h0, o_instr_ren}, 32'h0);
    cyc();
    i_ready = 1'b1;
    repeat (8) cyc();

    // Fill the FIFO, then redirect.
    i_ready = 1'b0;
    repeat (6) cyc();
    redirect_to(32'h100);
    measure("redir_full", 32'h100);
    cyc();
    i_ready = 1'b1;
    repeat (4) cyc();

    // Unaligned target and address wrap.
    redirect_to(32'h203);
    measure("redir_unaligned", 32'h200);
    cyc();
    redirect_to(32'hFFFF_FFFC);
    @(negedge clk_sys);
    chk("wrap_ren0", {31'h0, o_instr_ren}, 32'h1);
    chk("wrap_addr0", o_instr_raddr, 32'hFFFF_FFFC);
    @(negedge clk_sys);
    chk("wrap_ren1", {31'h0, o_instr_ren}, 32'h1);
    chk("wrap_addr1", o_instr_raddr, 32'h0000_0000);
    repeat (6) cyc();

    // Reset asserted mid-stream takes effect immediately.
    assert_reset();
    #1;
    chk("async_rst_valid", {31'h0, o_valid}, 32'h0);
    chk("async_rst_ren", {31'h0, o_instr_ren}, 32'h0);
    cyc();
    cyc();
    release_reset();
    measure("rst_midstream", RESET_PC);

    // Randomised traffic: backpressure, redirects and occasional resets.
    seg = 0;
    for (int it = 0; it < 1500; it++) begin
      cyc();
      i_ready = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      seg++;
      if (r < 4 || seg > 900) begin
        seg = 0;
        if ($urandom_range(0, 1) == 1) t = $urandom;
        else                           t = 32'($urandom_range(0, 32'h3FFF));
        start_redirect(t);
        finish_redirect();
      end else if (r == 4) begin
        seg = 0;
        assert_reset();
        cyc();
        cyc();
        release_reset();
      end
    end

    i_ready = 1'b1;
    repeat (20) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "simulation time limit reached");
  end

endmodule
